dme_pulse_pair_gen: RTL and testbench

Transmit-side DME interrogation pulse-pair generator. On a start request it emits a stream of baseband envelope samples, one per clk, forming two identical trapezoidal pulses. The pulse leading edges are separated by the X-mode or Y-mode code spacing. It also emits a ranging reference marker, t0_mark, at the half-amplitude point of pulse 1. The output stream feeds the DAC/modulator path. It is shaped to be compatible with the receive-side magnitude averaging chain, so loopback tests run without format conversion.

---
 rtl/dme_pulse_pair_gen.sv | 139 +++++++++++++
 tb/tb_dme_pulse_pair_gen.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/dme_pulse_pair_gen.sv
// DME interrogation pulse-pair generator: two trapezoidal envelope pulses
// separated by the X/Y code spacing, with a t0 marker on pulse 1's half-amplitude sample.
module dme_pulse_pair_gen #(
  parameter int WIDTH     = 24,
  parameter int RAMP_LOG2 = 4,
  parameter int FLAT      = 20,
  parameter int SPACING_X = 240,
  parameter int SPACING_Y = 720
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             mode_y,
  input  logic [WIDTH-2:0] amp,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             done,
  output logic             t0_mark,
  output logic [1:0]       dbg_state
);

  localparam int R    = 1 << RAMP_LOG2;
  localparam int P    = 2 * R + FLAT;
  localparam int SMAX = (SPACING_Y > SPACING_X) ? SPACING_Y : SPACING_X;
  localparam int CW   = $clog2(SMAX + 1);
  localparam int PW   = (WIDTH - 1) + (RAMP_LOG2 + 1);
  localparam int T0   = R / 2 - 1;
  localparam bit GAP_X = SPACING_X > P;
  localparam bit GAP_Y = SPACING_Y > P;
  localparam int GLAST_X = GAP_X ? SPACING_X - P - 1 : 0;
  localparam int GLAST_Y = GAP_Y ? SPACING_Y - P - 1 : 0;

  // Handshake: none on the output side; sample_out is meaningful only while
  // sample_valid=1, and the stream cannot be stalled once a burst starts.
  typedef enum logic [1:0] {IDLE, PULSE1, GAP, PULSE2} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-2:0] amp_q;
  logic             mode_q;

  logic [RAMP_LOG2:0] mult;
  logic [PW-1:0]      prod;
  logic [WIDTH-2:0]   env;
  logic               pulse_last;
  logic               has_gap;
  logic [CW-1:0]      gap_last;

  assign dbg_state = state;

  // Envelope for the current intra-pulse index; the ramp multiplier never exceeds R,
  // so the floored product stays <= amp.
  always_comb begin
    mult = '0;
    if (cnt < CW'(R)) begin
      mult = (RAMP_LOG2 + 1)'(cnt + CW'(1));
    end else begin
      mult = (RAMP_LOG2 + 1)'(CW'(P - 1) - cnt);
    end
    prod = PW'(amp_q) * PW'(mult);
    if (cnt >= CW'(R) && cnt < CW'(R + FLAT)) begin
      env = amp_q;
    end else begin
      env = (WIDTH - 1)'(prod >> RAMP_LOG2);
    end
  end

  assign pulse_last = (cnt == CW'(P - 1));
  assign has_gap    = mode_q ? GAP_Y : GAP_X;
  assign gap_last   = mode_q ? CW'(GLAST_Y) : CW'(GLAST_X);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      amp_q        <= '0;
      mode_q       <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      t0_mark      <= 1'b0;
    end else begin
      done    <= 1'b0;
      t0_mark <= 1'b0;
      case (state)
        IDLE: begin
          sample_out   <= '0;
          sample_valid <= 1'b0;
          busy         <= 1'b0;
          cnt          <= '0;
          if (start) begin
            amp_q  <= amp;
            mode_q <= mode_y;
            state  <= PULSE1;
          end
        end
        PULSE1: begin
          sample_out   <= {1'b0, env};
          sample_valid <= 1'b1;
          busy         <= 1'b1;
          t0_mark      <= (T0 >= 0) && (cnt == CW'(T0));
          if (pulse_last) begin
            cnt   <= '0;
            state <= has_gap ? GAP : PULSE2;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          sample_out   <= '0;
          sample_valid <= 1'b1;
          busy         <= 1'b1;
          if (cnt == gap_last) begin
            cnt   <= '0;
            state <= PULSE2;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PULSE2: begin
          sample_out   <= {1'b0, env};
          sample_valid <= 1'b1;
          busy         <= 1'b1;
          if (pulse_last) begin
            done  <= 1'b1;
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dme_pulse_pair_gen.sv
// Directed bench for dme_pulse_pair_gen: pulse-shape vectors in a table plus
// hand-written sequences for ignored inputs, held start and mid-burst reset.
module tb_dme_pulse_pair_gen;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        mode_y;
  logic [22:0] amp;
  logic [23:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        done;
  logic        t0_mark;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  dme_pulse_pair_gen #(
    .WIDTH(24), .RAMP_LOG2(2), .FLAT(3), .SPACING_X(20), .SPACING_Y(40)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode_y(mode_y), .amp(amp),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .done(done), .t0_mark(t0_mark), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              mode_y;
    logic [22:0]       amp;
    int                p2_cyc;
    int                done_cyc;
    logic [0:10][23:0] pulse;
  } vec_t;

  vec_t        vec[5];
  logic [27:0] cap[0:127];

  function automatic logic [27:0] pack_out();
    return {sample_valid, busy, done, t0_mark, sample_out};
  endfunction

  // Expected {valid, busy, done, t0, sample} at cycle c of a burst whose start
  // is sampled at cycle 0.
  function automatic logic [27:0] exp_at(input int v, input int c);
    logic [23:0] s;
    logic        val;
    s   = '0;
    val = (c >= 1) && (c <= vec[v].done_cyc);
    if (c >= 1 && c <= 11) s = vec[v].pulse[c-1];
    else if (c >= vec[v].p2_cyc && c <= vec[v].done_cyc) s = vec[v].pulse[c-vec[v].p2_cyc];
    return {val, val, (c == vec[v].done_cyc), (c == 2), s};
  endfunction

  task automatic check(input string name, input int c, input logic [27:0] act, input logic [27:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: actual v/b/d/t0=%b sample=%0d, expected v/b/d/t0=%b sample=%0d",
               name, c, act[27:24], act[23:0], exp[27:24], exp[23:0]);
    end
  endtask

  // kind: 0 plain, 1 ignored-input perturbation, 2 start held, 3 reset at cycle 15
  task automatic run_burst(input logic [22:0] a, input logic m, input int kind, input int ncyc);
    amp    = a;
    mode_y = m;
    start  = 1'b1;
    @(posedge clk); #1;
    cap[0] = pack_out();
    start  = (kind == 2);
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      cap[c] = pack_out();
      if (kind == 1) begin
        start = (c + 1 == 5) || (c + 1 == 31);
        if (c + 1 == 3) begin
          amp    = 23'd7;
          mode_y = ~m;
        end
      end
      if (kind == 3) resetn = (c != 15);
    end
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  initial begin
    vec[0].mode_y = 1'b0; vec[0].amp = 23'd1000; vec[0].p2_cyc = 21; vec[0].done_cyc = 31;
    vec[0].pulse  = {24'd250, 24'd500, 24'd750, 24'd1000, 24'd1000, 24'd1000, 24'd1000,
                     24'd750, 24'd500, 24'd250, 24'd0};
    vec[1].mode_y = 1'b1; vec[1].amp = 23'd1000; vec[1].p2_cyc = 41; vec[1].done_cyc = 51;
    vec[1].pulse  = vec[0].pulse;
    vec[2].mode_y = 1'b0; vec[2].amp = 23'd3; vec[2].p2_cyc = 21; vec[2].done_cyc = 31;
    vec[2].pulse  = {24'd0, 24'd1, 24'd2, 24'd3, 24'd3, 24'd3, 24'd3, 24'd2, 24'd1, 24'd0, 24'd0};
    vec[3].mode_y = 1'b0; vec[3].amp = 23'd8388607; vec[3].p2_cyc = 21; vec[3].done_cyc = 31;
    vec[3].pulse  = {24'd2097151, 24'd4194303, 24'd6291455, 24'd8388607, 24'd8388607,
                     24'd8388607, 24'd8388607, 24'd6291455, 24'd4194303, 24'd2097151, 24'd0};
    vec[4].mode_y = 1'b1; vec[4].amp = 23'd0; vec[4].p2_cyc = 41; vec[4].done_cyc = 51;
    vec[4].pulse  = '0;

    resetn = 1'b0; start = 1'b0; mode_y = 1'b0; amp = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", 0, pack_out(), 28'd0);
    check("reset_state", 0, {26'd0, dbg_state}, 28'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // table-driven shapes and timings
    for (int v = 0; v < 5; v++) begin
      run_burst(vec[v].amp, vec[v].mode_y, 0, vec[v].done_cyc + 3);
      for (int c = 0; c <= vec[v].done_cyc + 3; c++)
        check($sformatf("vec%0d", v), c, cap[c], exp_at(v, c));
    end

    // start re-pulsed mid-burst and at done, amp/mode changed mid-burst
    run_burst(23'd1000, 1'b0, 1, 40);
    for (int c = 0; c <= 40; c++) check("ignored", c, cap[c], exp_at(0, c));

    // start held high: bursts repeat every 32 cycles with one idle cycle
    run_burst(23'd1000, 1'b0, 2, 64);
    for (int c = 0; c <= 64; c++) check("held", c, cap[c], exp_at(0, (c <= 32) ? c : c - 32));
    repeat (40) @(posedge clk);
    #1;
    check("held_drain", 0, pack_out(), 28'd0);

    // reset lowered during cycle 15 aborts the burst
    run_burst(23'd1000, 1'b0, 3, 20);
    for (int c = 0; c <= 15; c++) check("rst_pre", c, cap[c], exp_at(0, c));
    for (int c = 16; c <= 20; c++) check("rst_post", c, cap[c], 28'd0);
    check("rst_state", 20, {26'd0, dbg_state}, 28'd0);

    run_burst(vec[0].amp, vec[0].mode_y, 0, 34);
    for (int c = 0; c <= 34; c++) check("post_rst", c, cap[c], exp_at(0, c));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
